// File: rtl/proj_sel_pkg.sv
// rtl/proj_sel_pkg.sv - shared constants and types for the project select controller
package proj_sel_pkg;

    localparam int MAX_PROJECTS = 32;

    localparam logic [1:0] REG_SELECT = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_SETTLE = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam int SEL_EN_BIT      = 31;
    localparam int STATUS_BUSY_BIT = 8;
    localparam int STATUS_ON_BIT   = 9;
    localparam int STATUS_ERR_BIT  = 16;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ON    = 2'd2
    } state_e;

endpackage

// File: rtl/wb_reg_slave.sv
// rtl/wb_reg_slave.sv - Wishbone decode, single-cycle ack and byte-lane write strobes
module wb_reg_slave
    import proj_sel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    input  logic [31:0] adr_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    input  logic [31:0] rd_select_i,
    input  logic [31:0] rd_status_i,
    input  logic [31:0] rd_settle_i,
    input  logic [31:0] rd_count_i,
    output logic [3:0]  wr_o,
    output logic [31:0] wr_mask_o,
    output logic [31:0] wr_data_o
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        accept;
    logic [31:0] rd_mux;
    logic        unused_adr;

    assign unused_adr = ^adr_i[1:0];

    // A hit while ack is still high is ignored, giving one access per two cycles.
    assign accept = stb_i && cyc_i && (adr_i[31:4] == BASE_ADDR[31:4]) && !ack_q;

    always_comb begin
        rd_mux = 32'd0;
        case (adr_i[3:2])
            REG_SELECT: rd_mux = rd_select_i;
            REG_STATUS: rd_mux = rd_status_i;
            REG_SETTLE: rd_mux = rd_settle_i;
            REG_COUNT:  rd_mux = rd_count_i;
            default:    rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        ack_d = accept;
        dat_d = accept ? rd_mux : 32'd0;
        wr_o  = (accept && we_i) ? (4'b0001 << adr_i[3:2]) : 4'b0000;
    end

    assign wr_mask_o = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign wr_data_o = dat_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/project_select_ctrl.sv
// rtl/project_select_ctrl.sv - one-hot project enable generator with an all-off drain window
module project_select_ctrl
    import proj_sel_pkg::*;
#(
    parameter int          NUM_PROJECTS = 7,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          SETTLE_RESET = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        la_override,
    input  logic [31:0] la_active,
    output logic [31:0] active
);

    localparam logic [31:0] PROJ_MASK = 32'((64'd1 << NUM_PROJECTS) - 64'd1);

    state_e      state_q, state_d;
    logic [4:0]  tgt_q, tgt_d, cur_q, cur_d;
    logic        sel_en_q, sel_en_d;
    logic [15:0] settle_q, settle_d, cnt_q, cnt_d;
    logic [31:0] count_q, count_d, active_q, active_d;
    logic        err_q, err_d;

    logic [3:0]  wr;
    logic [31:0] wr_mask, wr_data, sel_merged;
    logic [31:0] rd_select, rd_status, rd_settle;
    logic        new_en, bad_idx, sel_valid;
    logic [4:0]  new_idx;
    logic [15:0] settle_load;

    assign rd_select = {sel_en_q, 26'd0, tgt_q};
    assign rd_status = {15'd0, err_q, 6'd0, state_q == ST_ON, state_q == ST_DRAIN, 3'd0, cur_q};
    assign rd_settle = {16'd0, settle_q};

    wb_reg_slave #(.BASE_ADDR(BASE_ADDR)) u_regs (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .stb_i       (wbs_stb_i),
        .cyc_i       (wbs_cyc_i),
        .we_i        (wbs_we_i),
        .sel_i       (wbs_sel_i),
        .dat_i       (wbs_dat_i),
        .adr_i       (wbs_adr_i),
        .ack_o       (wbs_ack_o),
        .dat_o       (wbs_dat_o),
        .rd_select_i (rd_select),
        .rd_status_i (rd_status),
        .rd_settle_i (rd_settle),
        .rd_count_i  (count_q),
        .wr_o        (wr),
        .wr_mask_o   (wr_mask),
        .wr_data_o   (wr_data)
    );

    // Validity is judged on the byte-merged SELECT value, not the raw bus data.
    assign sel_merged  = (rd_select & ~wr_mask) | (wr_data & wr_mask);
    assign new_en      = sel_merged[SEL_EN_BIT];
    assign new_idx     = sel_merged[4:0];
    assign bad_idx     = new_en && ({27'd0, new_idx} >= 32'(NUM_PROJECTS));
    assign sel_valid   = wr[REG_SELECT] && !bad_idx;
    assign settle_load = (settle_q == 16'd0) ? 16'd1 : settle_q;

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cur_d    = cur_q;
        sel_en_d = sel_en_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        err_d    = err_q;

        if (wr[REG_SELECT] && bad_idx)
            err_d = 1'b1;
        if (wr[REG_STATUS] && wr_mask[STATUS_ERR_BIT] && wr_data[STATUS_ERR_BIT])
            err_d = 1'b0;
        if (wr[REG_SETTLE])
            settle_d = (settle_q & ~wr_mask[15:0]) | (wr_data[15:0] & wr_mask[15:0]);
        if (sel_valid) begin
            sel_en_d = new_en;
            tgt_d    = new_idx;
        end

        case (state_q)
            ST_OFF: begin
                if (sel_valid && new_en) begin
                    state_d = ST_DRAIN;
                    cnt_d   = settle_load;
                end
            end
            ST_DRAIN: begin
                if (sel_valid) begin
                    if (new_en) cnt_d = settle_load;
                    else        state_d = ST_OFF;
                end else if (cnt_q <= 16'd1) begin
                    state_d = ST_ON;
                    cur_d   = tgt_q;
                    count_d = count_q + 32'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_ON: begin
                if (sel_valid) begin
                    if (!new_en) begin
                        state_d = ST_OFF;
                    end else if (new_idx != cur_q) begin
                        state_d = ST_DRAIN;
                        cnt_d   = settle_load;
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase

        if (wr[REG_COUNT])
            count_d = 32'd0;

        // Enable only once ON has held for a full cycle, so a leaving write drops it at once.
        active_d = ((state_q == ST_ON) && (state_d == ST_ON)) ? (32'd1 << cur_q) : 32'd0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_OFF;
            tgt_q    <= 5'd0;
            cur_q    <= 5'd0;
            sel_en_q <= 1'b0;
            settle_q <= 16'(SETTLE_RESET);
            cnt_q    <= 16'd0;
            count_q  <= 32'd0;
            err_q    <= 1'b0;
            active_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            cur_q    <= cur_d;
            sel_en_q <= sel_en_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign active = la_override ? (la_active & PROJ_MASK) : active_q;

endmodule
